// File: rtl/data_demux_pkg.sv
`default_nettype none
// ============================================================================
// Module  : data_demux_pkg
// Purpose : Shared constants and helpers for the data_demux_hs slice.
//           logb2(n) returns the number of bits needed to encode 0..n-1.
//           Its minimum is 1, so a one-channel configuration still has a
//           one-bit select.
// Revision: 1.0 - initial release
// ============================================================================
package data_demux_pkg;

    // Default width of the drop counter.
    localparam int c_cntwid = 16;

    // ceil(log2(n)) with a floor of 1.
    function automatic int logb2(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/data_demux_hs_if.sv
`default_nettype none
// ============================================================================
// Module  : data_demux_hs_if
// Purpose : Handshake bundle for data_demux_hs.
//   din/sel/bcast/din_vld -> input word with destination select
//   din_rdy               <- input word accepted when high with din_vld
//   dout/dout_vld         <- per-channel head word and valid
//   dout_rdy              -> per-channel ready
//   master : the side that drives words in and consumes channels
//   slave  : the demux itself
// Revision: 1.0 - initial release
// ============================================================================
interface data_demux_hs_if
    import data_demux_pkg::*;
#(
    parameter int CHN_NUM = 6,
    parameter int DWID    = 256,
    parameter int NUMWID  = logb2(CHN_NUM)
);
    logic [DWID-1:0]         din;
    logic [NUMWID-1:0]       sel;
    logic                    bcast;
    logic                    din_vld;
    logic                    din_rdy;
    logic [DWID*CHN_NUM-1:0] dout;
    logic [CHN_NUM-1:0]      dout_vld;
    logic [CHN_NUM-1:0]      dout_rdy;

    modport master (
        output din, sel, bcast, din_vld, dout_rdy,
        input  din_rdy, dout, dout_vld
    );

    modport slave (
        input  din, sel, bcast, din_vld, dout_rdy,
        output din_rdy, dout, dout_vld
    );
endinterface
`default_nettype wire

// File: rtl/chn_fifo.sv
`default_nettype none
// ============================================================================
// Module  : chn_fifo
// Purpose : Single-channel synchronous FIFO, DEPTH entries (power of 2).
//   push/din -> write when not full
//   full     <- registered occupancy == DEPTH (a same-cycle pop does not
//               free a slot)
//   pop      -> read when valid
//   valid    <- occupancy != 0
//   head     <- oldest entry (raw storage; the caller masks it with valid)
// Revision: 1.0 - initial release
// ============================================================================
module chn_fifo #(
    parameter int DWID  = 256,
    parameter int DEPTH = 4
) (
    input  wire logic            clk,
    input  wire logic            rst,
    input  wire logic            push,
    input  wire logic [DWID-1:0] din,
    output logic                 full,
    input  wire logic            pop,
    output logic                 valid,
    output logic [DWID-1:0]      head
);
    localparam int              c_aw    = $clog2(DEPTH);
    localparam logic [c_aw:0]   c_depth = (c_aw + 1)'(DEPTH);

    logic [DWID-1:0] r_mem [DEPTH];
    logic [c_aw-1:0] r_wr;
    logic [c_aw-1:0] r_rd;
    logic [c_aw:0]   r_cnt;
    logic            w_push;
    logic            w_pop;

    assign full   = (r_cnt == c_depth);
    assign valid  = (r_cnt != '0);
    assign w_push = push & ~full;
    assign w_pop  = pop & valid;
    assign head   = r_mem[r_rd];

    // Pointers wrap naturally because DEPTH is a power of 2.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wr <= r_wr + 1'b1;
            end
            if (w_pop) begin
                r_rd <= r_rd + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Storage is not reset. A stray write during reset is harmless because
    // the pointers restart at zero.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr] <= din;
        end
    end
endmodule
`default_nettype wire

// File: rtl/data_demux_hs.sv
`default_nettype none
// ============================================================================
// Module  : data_demux_hs
// Purpose : Handshaked 1-to-CHN_NUM demux with a FIFO per output channel.
//   clk, rst  : clock, synchronous active-high reset
//   bus       : data_demux_hs_if.slave (din/sel/bcast/din_vld/din_rdy,
//               dout/dout_vld/dout_rdy)
//   drop_cnt  : saturating count of accepted words whose select was out of
//               range
//   Unicast goes to FIFO[sel]. Broadcast writes every FIFO in the same cycle
//   and waits until all of them have room. An out-of-range select is always
//   ready and discards the word.
// Revision: 1.0 - initial release
// ============================================================================
module data_demux_hs
    import data_demux_pkg::*;
#(
    parameter int CHN_NUM = 6,
    parameter int DWID    = 256,
    parameter int DEPTH   = 4,
    parameter int NUMWID  = logb2(CHN_NUM),
    parameter int CNTWID  = c_cntwid
) (
    input  wire logic         clk,
    input  wire logic         rst,
    data_demux_hs_if.slave    bus,
    output logic [CNTWID-1:0] drop_cnt
);
    logic [CHN_NUM-1:0]  w_onehot;
    logic [CHN_NUM-1:0]  w_full;
    logic [CHN_NUM-1:0]  w_vld;
    logic [CHN_NUM-1:0]  w_push;
    logic [DWID-1:0]     w_head [CHN_NUM];
    logic [DWID*CHN_NUM-1:0] w_dout;
    logic                w_rdy;
    logic                w_accept;
    logic                w_drop;
    logic [CNTWID-1:0]   r_drop;

    // Select decode. An out-of-range sel gives an all-zero vector, which
    // also makes the unicast ready term equal to 1.
    always_comb begin
        w_onehot = '0;
        for (int i = 0; i < CHN_NUM; i++) begin
            w_onehot[i] = ({1'b0, bus.sel} == (NUMWID + 1)'(i));
        end
    end

    assign w_rdy    = bus.bcast ? ~|w_full : ~|(w_full & w_onehot);
    assign w_accept = bus.din_vld & w_rdy;
    assign w_drop   = w_accept & ~bus.bcast & ~|w_onehot;

    always_comb begin
        w_push = '0;
        for (int i = 0; i < CHN_NUM; i++) begin
            w_push[i] = w_accept & (bus.bcast | w_onehot[i]);
        end
    end

    generate
        for (genvar i = 0; i < CHN_NUM; i++) begin : g_chn
            chn_fifo #(
                .DWID  (DWID),
                .DEPTH (DEPTH)
            ) u_fifo (
                .clk   (clk),
                .rst   (rst),
                .push  (w_push[i]),
                .din   (bus.din),
                .full  (w_full[i]),
                .pop   (bus.dout_rdy[i]),
                .valid (w_vld[i]),
                .head  (w_head[i])
            );
        end
    endgenerate

    // Hold a channel slice at zero whenever that channel has nothing valid.
    always_comb begin
        w_dout = '0;
        for (int i = 0; i < CHN_NUM; i++) begin
            w_dout[DWID*i +: DWID] = w_vld[i] ? w_head[i] : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop <= '0;
        end else if (w_drop && (r_drop != '1)) begin
            r_drop <= r_drop + 1'b1;
        end
    end

    assign bus.din_rdy  = w_rdy;
    assign bus.dout     = w_dout;
    assign bus.dout_vld = w_vld;
    assign drop_cnt     = r_drop;
endmodule
`default_nettype wire

// File: tb/tb_data_demux_hs.sv
`default_nettype none
// ============================================================================
// Module  : tb_data_demux_hs
// Purpose : Self-checking bench for data_demux_hs. A queue-per-channel model
//           is checked against the DUT on every falling edge. Directed
//           scenarios add literal expectations.
// Revision: 1.0 - initial release
// ============================================================================
module tb_data_demux_hs;
    localparam int CH    = 6;
    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int NW    = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] drop_cnt;
    logic [1:0]  drop_cnt2;

    data_demux_hs_if #(.CHN_NUM(CH), .DWID(DW), .NUMWID(NW)) bus ();
    data_demux_hs_if #(.CHN_NUM(CH), .DWID(DW), .NUMWID(NW)) bus2 ();

    data_demux_hs #(.CHN_NUM(CH), .DWID(DW), .DEPTH(DEPTH), .NUMWID(NW), .CNTWID(16)) dut (
        .clk(clk), .rst(rst), .bus(bus), .drop_cnt(drop_cnt)
    );

    data_demux_hs #(.CHN_NUM(CH), .DWID(DW), .DEPTH(DEPTH), .NUMWID(NW), .CNTWID(2)) dut2 (
        .clk(clk), .rst(rst), .bus(bus2), .drop_cnt(drop_cnt2)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [DW-1:0] mq [CH][$];
    logic [15:0]   mdrop   = '0;
    logic          started = 1'b0;

    function automatic logic model_rdy();
        if (bus.bcast) begin
            for (int i = 0; i < CH; i++) begin
                if (mq[i].size() >= DEPTH) return 1'b0;
            end
            return 1'b1;
        end
        if (int'(bus.sel) < CH) return (mq[bus.sel].size() < DEPTH);
        return 1'b1;
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                for (int i = 0; i < CH; i++) mq[i].delete();
                mdrop   = '0;
                started = 1'b1;
            end else if (started) begin
                logic acc;
                acc = bus.din_vld && model_rdy();
                for (int i = 0; i < CH; i++) begin
                    if (mq[i].size() > 0 && bus.dout_rdy[i]) void'(mq[i].pop_front());
                end
                if (acc) begin
                    if (bus.bcast) begin
                        for (int i = 0; i < CH; i++) mq[i].push_back(bus.din);
                    end else if (int'(bus.sel) < CH) begin
                        mq[bus.sel].push_back(bus.din);
                    end else if (mdrop != 16'hFFFF) begin
                        mdrop = mdrop + 16'd1;
                    end
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (started) begin
                logic [CH-1:0] ev;
                for (int i = 0; i < CH; i++) begin
                    ev[i] = (mq[i].size() > 0);
                    check("model_slice", bus.dout[DW*i +: DW], ev[i] ? mq[i][0] : '0);
                end
                check("model_dout_vld", bus.dout_vld, ev);
                check("model_din_rdy", bus.din_rdy, model_rdy());
                check("model_drop_cnt", drop_cnt, mdrop);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic vld, input logic [NW-1:0] s, input logic bc, input logic [DW-1:0] d);
        bus.din_vld = vld;
        bus.sel     = s;
        bus.bcast   = bc;
        bus.din     = d;
    endtask

    initial begin
        drive(1'b0, '0, 1'b0, '0);
        bus.dout_rdy  = '1;
        bus2.din_vld  = 1'b0;
        bus2.sel      = '0;
        bus2.bcast    = 1'b0;
        bus2.din      = '0;
        bus2.dout_rdy = '1;

        // Reset state
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        check("rst_dout_vld", bus.dout_vld, 0);
        check("rst_drop_cnt", drop_cnt, 0);
        check("rst_din_rdy", bus.din_rdy, 1);

        // Unicast to channel 2
        drive(1'b1, 3'd2, 1'b0, 32'hA5);
        step();
        drive(1'b0, '0, 1'b0, '0);
        check("uni_vld", bus.dout_vld, 6'b000100);
        check("uni_slice2", bus.dout[64 +: 32], 32'hA5);
        check("uni_slice0", bus.dout[0 +: 32], 0);
        check("uni_slice5", bus.dout[160 +: 32], 0);
        step();
        check("uni_empty", bus.dout_vld, 0);

        // Full on channel 1
        bus.dout_rdy = 6'b111101;
        for (int w = 1; w <= 4; w++) begin
            drive(1'b1, 3'd1, 1'b0, 32'(w));
            step();
        end
        drive(1'b1, 3'd1, 1'b0, 32'd5);
        #1;
        check("full_rdy5", bus.din_rdy, 0);
        step();
        check("full_head1", bus.dout[32 +: 32], 1);
        bus.dout_rdy = '1;
        #1;
        check("full_nopass", bus.din_rdy, 0);
        step();
        check("full_head2", bus.dout[32 +: 32], 2);
        check("full_rdy_after", bus.din_rdy, 1);
        step();
        drive(1'b0, '0, 1'b0, '0);
        check("full_head3", bus.dout[32 +: 32], 3);
        step();
        check("full_head4", bus.dout[32 +: 32], 4);
        step();
        check("full_head5", bus.dout[32 +: 32], 5);
        step();
        check("full_drained", bus.dout_vld, 0);

        // Simultaneous push/pop around a full FIFO on channel 0
        bus.dout_rdy = 6'b111110;
        for (int w = 10; w <= 13; w++) begin
            drive(1'b1, 3'd0, 1'b0, 32'(w));
            step();
        end
        drive(1'b1, 3'd0, 1'b0, 32'd14);
        bus.dout_rdy = '1;
        #1;
        check("pp_full_rdy", bus.din_rdy, 0);
        step();
        check("pp_head11", bus.dout[0 +: 32], 11);
        check("pp_rdy3", bus.din_rdy, 1);
        step();
        check("pp_head12", bus.dout[0 +: 32], 12);
        drive(1'b1, 3'd0, 1'b0, 32'd15);
        bus.dout_rdy = 6'b111110;
        step();
        drive(1'b1, 3'd0, 1'b0, 32'd16);
        #1;
        check("pp_full_again", bus.din_rdy, 0);
        drive(1'b0, '0, 1'b0, '0);
        bus.dout_rdy = '1;
        for (int k = 0; k < 4; k++) step();
        check("pp_drained", bus.dout_vld, 0);

        // Broadcast blocked by a full channel 3
        bus.dout_rdy = 6'b110111;
        for (int w = 20; w <= 23; w++) begin
            drive(1'b1, 3'd3, 1'b0, 32'(w));
            step();
        end
        drive(1'b1, 3'd5, 1'b1, 32'hBB);
        #1;
        check("bc_blocked", bus.din_rdy, 0);
        step();
        check("bc_none_written", bus.dout_vld, 6'b001000);
        bus.dout_rdy = '1;
        #1;
        check("bc_nopass", bus.din_rdy, 0);
        step();
        bus.dout_rdy = 6'b110111;
        #1;
        check("bc_ready", bus.din_rdy, 1);
        step();
        drive(1'b0, '0, 1'b0, '0);
        check("bc_all_vld", bus.dout_vld, 6'b111111);
        check("bc_slice0", bus.dout[0 +: 32], 32'hBB);
        check("bc_slice5", bus.dout[160 +: 32], 32'hBB);
        check("bc_slice3", bus.dout[96 +: 32], 21);
        bus.dout_rdy = '1;
        for (int k = 0; k < 4; k++) step();
        check("bc_drained", bus.dout_vld, 0);

        // Drops on an out-of-range select
        drive(1'b1, 3'd7, 1'b0, 32'h55);
        #1;
        check("drop_rdy", bus.din_rdy, 1);
        for (int k = 0; k < 3; k++) step();
        drive(1'b0, '0, 1'b0, '0);
        check("drop_cnt3", drop_cnt, 3);
        check("drop_no_vld", bus.dout_vld, 0);

        // Saturation of a 2-bit drop counter
        bus2.din_vld = 1'b1;
        bus2.sel     = 3'd7;
        bus2.din     = 32'h66;
        for (int k = 0; k < 3; k++) step();
        check("sat_cnt3", drop_cnt2, 3);
        step();
        step();
        bus2.din_vld = 1'b0;
        check("sat_cnt5", drop_cnt2, 3);
        check("sat_no_vld", bus2.dout_vld, 0);

        // Reset while channel 0 holds 3 words; the handshake in the reset
        // cycle is ignored.
        bus.dout_rdy = 6'b111110;
        for (int w = 30; w <= 32; w++) begin
            drive(1'b1, 3'd0, 1'b0, 32'(w));
            step();
        end
        drive(1'b1, 3'd0, 1'b0, 32'd33);
        rst = 1'b1;
        step();
        rst = 1'b0;
        drive(1'b0, '0, 1'b0, '0);
        check("mrst_vld", bus.dout_vld, 0);
        check("mrst_drop", drop_cnt, 0);
        drive(1'b1, 3'd0, 1'b0, 32'd40);
        bus.dout_rdy = '1;
        step();
        drive(1'b0, '0, 1'b0, '0);
        check("mrst_fresh_vld", bus.dout_vld, 6'b000001);
        check("mrst_fresh_data", bus.dout[0 +: 32], 40);
        step();
        check("mrst_empty", bus.dout_vld, 0);

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
